// File: rtl/parser_rule_ctrl.sv
// parser_rule_ctrl: configuration front-end for the Parser_Top rule bus.
// Replays a boot-time rule image from a config ROM, arbitrates it against
// single-word host reads/writes, and returns host read data with a timeout.
module parser_rule_ctrl #(
   parameter int unsigned ROM_AW     = 6,
   parameter int unsigned RD_TIMEOUT = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_boot_start,
   input  logic [ROM_AW:0]     i_boot_len,
   output logic                o_boot_busy,
   output logic                o_boot_done,
   output logic                o_rom_rden,
   output logic [ROM_AW-1:0]   o_rom_addr,
   input  logic [63:0]         i_rom_data,
   input  logic                i_host_valid,
   output logic                o_host_ready,
   input  logic                i_host_wr,
   input  logic [31:0]         i_host_addr,
   input  logic [31:0]         i_host_wdata,
   output logic                o_host_rvalid,
   output logic [31:0]         o_host_rdata,
   output logic                o_host_rerr,
   output logic                o_rule_wren,
   output logic                o_rule_rden,
   output logic [31:0]         o_rule_addr,
   output logic [31:0]         o_rule_wdata,
   input  logic                i_rule_rdata_valid,
   input  logic [31:0]         i_rule_rdata
);

   localparam int unsigned LEN_W = ROM_AW + 1;
   localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      BOOT_RD,
      BOOT_WR,
      HOST_RD_WAIT
   } state_e;

   state_e              state_q, state_d;
   logic [ROM_AW-1:0]   idx_q, idx_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                pending_q, pending_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                boot_busy_q, boot_busy_d;
   logic                boot_done_q, boot_done_d;
   logic                rom_rden_q, rom_rden_d;
   logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
   logic                host_rvalid_q, host_rvalid_d;
   logic [31:0]         host_rdata_q, host_rdata_d;
   logic                host_rerr_q, host_rerr_d;
   logic                rule_wren_q, rule_wren_d;
   logic                rule_rden_q, rule_rden_d;
   logic [31:0]         rule_addr_q, rule_addr_d;
   logic [31:0]         rule_wdata_q, rule_wdata_d;

   logic                boot_active;
   logic                last_entry;
   logic [LEN_W-1:0]    eff_len;

   assign o_host_ready  = (state_q == IDLE) && !pending_q && !i_boot_start;

   assign o_boot_busy   = boot_busy_q;
   assign o_boot_done   = boot_done_q;
   assign o_rom_rden    = rom_rden_q;
   assign o_rom_addr    = rom_addr_q;
   assign o_host_rvalid = host_rvalid_q;
   assign o_host_rdata  = host_rdata_q;
   assign o_host_rerr   = host_rerr_q;
   assign o_rule_wren   = rule_wren_q;
   assign o_rule_rden   = rule_rden_q;
   assign o_rule_addr   = rule_addr_q;
   assign o_rule_wdata  = rule_wdata_q;

   // Next-state and next-output computation for the boot/host sequencer.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      len_d         = len_q;
      pending_d     = pending_q;
      cnt_d         = cnt_q;
      boot_done_d   = 1'b0;
      rom_rden_d    = 1'b0;
      rom_addr_d    = rom_addr_q;
      host_rvalid_d = 1'b0;
      host_rdata_d  = host_rdata_q;
      host_rerr_d   = host_rerr_q;
      rule_wren_d   = 1'b0;
      rule_rden_d   = 1'b0;
      rule_addr_d   = rule_addr_q;
      rule_wdata_d  = rule_wdata_q;
      eff_len       = '0;

      boot_active = (state_q == BOOT_RD) || (state_q == BOOT_WR);
      last_entry  = (({1'b0, idx_q} + LEN_W'(1)) == len_q);

      // Only the first start of a pending/active load is remembered.
      if (i_boot_start && !pending_q && !boot_active) begin
         pending_d = 1'b1;
         len_d     = i_boot_len;
      end

      case (state_q)
         IDLE: begin
            if (pending_q || i_boot_start) begin
               // A start seen in IDLE is served in the same cycle, so the
               // pending flag never outlives this decision.
               eff_len   = pending_q ? len_q : i_boot_len;
               pending_d = 1'b0;
               if (eff_len == '0) begin
                  boot_done_d = 1'b1;
               end else begin
                  idx_d      = '0;
                  rom_rden_d = 1'b1;
                  rom_addr_d = '0;
                  state_d    = BOOT_RD;
               end
            end else if (i_host_valid) begin
               rule_addr_d = i_host_addr;
               if (i_host_wr) begin
                  rule_wren_d  = 1'b1;
                  rule_wdata_d = i_host_wdata;
               end else begin
                  rule_rden_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = HOST_RD_WAIT;
               end
            end
         end
         BOOT_RD: begin
            state_d = BOOT_WR;
         end
         BOOT_WR: begin
            if (i_rom_data[63:32] == '1) begin
               boot_done_d = 1'b1;
               state_d     = IDLE;
            end else begin
               rule_wren_d  = 1'b1;
               rule_addr_d  = i_rom_data[63:32];
               rule_wdata_d = i_rom_data[31:0];
               if (last_entry) begin
                  boot_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  idx_d      = idx_q + ROM_AW'(1);
                  rom_rden_d = 1'b1;
                  rom_addr_d = idx_q + ROM_AW'(1);
                  state_d    = BOOT_RD;
               end
            end
         end
         HOST_RD_WAIT: begin
            if (i_rule_rdata_valid) begin
               host_rvalid_d = 1'b1;
               host_rdata_d  = i_rule_rdata;
               host_rerr_d   = 1'b0;
               state_d       = IDLE;
            end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
               host_rvalid_d = 1'b1;
               host_rdata_d  = '0;
               host_rerr_d   = 1'b1;
               state_d       = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      boot_busy_d = pending_d || (state_d == BOOT_RD) || (state_d == BOOT_WR);
   end

   // State and registered outputs; reset aborts any load or read silently.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         len_q         <= '0;
         pending_q     <= 1'b0;
         cnt_q         <= '0;
         boot_busy_q   <= 1'b0;
         boot_done_q   <= 1'b0;
         rom_rden_q    <= 1'b0;
         rom_addr_q    <= '0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
         host_rerr_q   <= 1'b0;
         rule_wren_q   <= 1'b0;
         rule_rden_q   <= 1'b0;
         rule_addr_q   <= '0;
         rule_wdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         len_q         <= len_d;
         pending_q     <= pending_d;
         cnt_q         <= cnt_d;
         boot_busy_q   <= boot_busy_d;
         boot_done_q   <= boot_done_d;
         rom_rden_q    <= rom_rden_d;
         rom_addr_q    <= rom_addr_d;
         host_rvalid_q <= host_rvalid_d;
         host_rdata_q  <= host_rdata_d;
         host_rerr_q   <= host_rerr_d;
         rule_wren_q   <= rule_wren_d;
         rule_rden_q   <= rule_rden_d;
         rule_addr_q   <= rule_addr_d;
         rule_wdata_q  <= rule_wdata_d;
      end
   end

endmodule

// File: tb/tb_parser_rule_ctrl.sv
// Bench for parser_rule_ctrl: ROM and rule-bus stubs, event monitor, and a
// transaction-level model that predicts ROM reads, rule writes/reads, host
// responses and boot completion cycle by cycle.
module tb_parser_rule_ctrl;

   localparam int unsigned ROM_AW     = 6;
   localparam int unsigned RD_TIMEOUT = 16;
   localparam int          HIST       = 20000;

   typedef struct {
      int          cyc;
      logic [63:0] v;
   } ev_t;

   logic              i_clk;
   logic              i_rst_n;
   logic              i_boot_start;
   logic [ROM_AW:0]   i_boot_len;
   logic              o_boot_busy;
   logic              o_boot_done;
   logic              o_rom_rden;
   logic [ROM_AW-1:0] o_rom_addr;
   logic [63:0]       rom_q;
   logic              i_host_valid;
   logic              o_host_ready;
   logic              i_host_wr;
   logic [31:0]       i_host_addr;
   logic [31:0]       i_host_wdata;
   logic              o_host_rvalid;
   logic [31:0]       o_host_rdata;
   logic              o_host_rerr;
   logic              o_rule_wren;
   logic              o_rule_rden;
   logic [31:0]       o_rule_addr;
   logic [31:0]       o_rule_wdata;
   logic              i_rule_rdata_valid;
   logic [31:0]       i_rule_rdata;

   logic [63:0] rom [0:63];
   logic        busy_hist [0:HIST-1];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          excl_viol = 0;

   ev_t wr_q[$], rd_q[$], romrd_q[$], rsp_q[$], done_q[$];
   ev_t exp_wr[$], exp_rd[$], exp_romrd[$], exp_rsp[$], exp_done[$];

   parser_rule_ctrl #(.ROM_AW(ROM_AW), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_boot_start       (i_boot_start),
      .i_boot_len         (i_boot_len),
      .o_boot_busy        (o_boot_busy),
      .o_boot_done        (o_boot_done),
      .o_rom_rden         (o_rom_rden),
      .o_rom_addr         (o_rom_addr),
      .i_rom_data         (rom_q),
      .i_host_valid       (i_host_valid),
      .o_host_ready       (o_host_ready),
      .i_host_wr          (i_host_wr),
      .i_host_addr        (i_host_addr),
      .i_host_wdata       (i_host_wdata),
      .o_host_rvalid      (o_host_rvalid),
      .o_host_rdata       (o_host_rdata),
      .o_host_rerr        (o_host_rerr),
      .o_rule_wren        (o_rule_wren),
      .o_rule_rden        (o_rule_rden),
      .o_rule_addr        (o_rule_addr),
      .o_rule_wdata       (o_rule_wdata),
      .i_rule_rdata_valid (i_rule_rdata_valid),
      .i_rule_rdata       (i_rule_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Synchronous ROM: data one cycle after the read strobe.
   always @(posedge i_clk) if (o_rom_rden) rom_q <= rom[o_rom_addr];

   function automatic ev_t mk(input int c, input logic [63:0] v);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      return e;
   endfunction

   // Event monitor, sampled on the falling edge.
   always @(negedge i_clk) begin
      if (o_rule_wren)   wr_q.push_back(mk(cyc, {o_rule_addr, o_rule_wdata}));
      if (o_rule_rden)   rd_q.push_back(mk(cyc, {32'h0, o_rule_addr}));
      if (o_rom_rden)    romrd_q.push_back(mk(cyc, 64'(o_rom_addr)));
      if (o_host_rvalid) rsp_q.push_back(mk(cyc, {31'h0, o_host_rerr, o_host_rdata}));
      if (o_boot_done)   done_q.push_back(mk(cyc, 64'd1));
      if (o_rule_wren && o_rule_rden) excl_viol <= excl_viol + 1;
      if (cyc < HIST) busy_hist[cyc] <= o_boot_busy;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_ev();
      wr_q.delete(); rd_q.delete(); romrd_q.delete(); rsp_q.delete(); done_q.delete();
      exp_wr.delete(); exp_rd.delete(); exp_romrd.delete(); exp_rsp.delete(); exp_done.delete();
   endtask

   task automatic cmp_ev(input string tag, input ev_t got[$], input ev_t exp[$]);
      check_value({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         check_value({tag, "_cycle"}, 64'(got[i].cyc), 64'(exp[i].cyc));
         check_value({tag, "_value"}, got[i].v, exp[i].v);
      end
   endtask

   task automatic check_all(input string tag);
      cmp_ev({tag, "_rulewr"}, wr_q, exp_wr);
      cmp_ev({tag, "_rulerd"}, rd_q, exp_rd);
      cmp_ev({tag, "_romrd"}, romrd_q, exp_romrd);
      cmp_ev({tag, "_hostrsp"}, rsp_q, exp_rsp);
      cmp_ev({tag, "_done"}, done_q, exp_done);
   endtask

   task automatic check_outs_zero(input string tag);
      check_value({tag, "_ctrl"}, 64'({o_boot_busy, o_boot_done, o_rom_rden, o_host_rvalid,
                                       o_host_rerr, o_rule_wren, o_rule_rden}), 64'd0);
      check_value({tag, "_romaddr"}, 64'(o_rom_addr), 64'd0);
      check_value({tag, "_hrdata"}, 64'(o_host_rdata), 64'd0);
      check_value({tag, "_raddr"}, 64'(o_rule_addr), 64'd0);
      check_value({tag, "_rwdata"}, 64'(o_rule_wdata), 64'd0);
   endtask

   // Busy must be high strictly between the start and the done pulse.
   task automatic check_busy(input int from, input int dn);
      for (int k = from; k <= dn; k++)
         check_value("boot_busy", 64'(busy_hist[k]), 64'(k < dn));
   endtask

   task automatic fill_rom(input int term);
      for (int i = 0; i < 64; i++) begin
         rom[i] = {$urandom, $urandom};
         if (rom[i][63:32] == 32'hFFFF_FFFF) rom[i][63] = 1'b0;
      end
      if (term >= 0 && term < 64) rom[term][63:32] = 32'hFFFF_FFFF;
   endtask

   // Model of a load whose IDLE decision happens in cycle c: one ROM read
   // per two cycles, each non-terminator entry written two cycles later,
   // completion with the last write or in the terminator's write slot.
   task automatic exp_boot(input int c, input int len, output int dn);
      dn = c + 1;
      for (int k = 0; k < len; k++) begin
         exp_romrd.push_back(mk(c + 1 + 2 * k, 64'(k)));
         dn = c + 3 + 2 * k;
         if (rom[k][63:32] == 32'hFFFF_FFFF) break;
         exp_wr.push_back(mk(c + 3 + 2 * k, rom[k]));
      end
      exp_done.push_back(mk(dn, 64'd1));
   endtask

   task automatic boot_pulse(input int len, output int c);
      i_boot_start = 1'b1;
      i_boot_len   = 7'(len);
      c = cyc;
      tick();
      i_boot_start = 1'b0;
   endtask

   task automatic host_req(input logic wr, input logic [31:0] a, input logic [31:0] d, output int acc);
      int n = 0;
      i_host_valid = 1'b1;
      i_host_wr    = wr;
      i_host_addr  = a;
      i_host_wdata = d;
      acc = -1;
      while (acc < 0 && n < 200) begin
         @(negedge i_clk);
         if (o_host_ready) acc = cyc;
         tick();
         n++;
      end
      i_host_valid = 1'b0;
      if (acc < 0) check_value("host_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic host_write(input logic [31:0] a, input logic [31:0] d, output int acc);
      host_req(1'b1, a, d, acc);
      exp_wr.push_back(mk(acc + 1, {a, d}));
   endtask

   // d < 0: the rule bus never answers.
   task automatic host_read(input logic [31:0] a, input int d, input logic [31:0] rd);
      int acc, r;
      host_req(1'b0, a, $urandom, acc);
      r = acc + 1;
      exp_rd.push_back(mk(r, {32'h0, a}));
      if (d >= 0) begin
         repeat (d) tick();
         i_rule_rdata_valid = 1'b1;
         i_rule_rdata       = rd;
         tick();
         i_rule_rdata_valid = 1'b0;
         i_rule_rdata       = $urandom;
         exp_rsp.push_back(mk(r + d + 1, {32'h0, rd}));
      end else begin
         repeat (RD_TIMEOUT) tick();
         exp_rsp.push_back(mk(r + RD_TIMEOUT, {31'h0, 1'b1, 32'h0}));
      end
      tick();
   endtask

   initial begin
      int c, dn, acc, acc2, len, term, sel, r;
      logic [31:0] a, d;

      i_rst_n = 1'b0; i_boot_start = 1'b0; i_boot_len = '0;
      i_host_valid = 1'b0; i_host_wr = 1'b0; i_host_addr = '0; i_host_wdata = '0;
      i_rule_rdata_valid = 1'b0; i_rule_rdata = '0;
      fill_rom(-1);
      repeat (3) @(posedge i_clk);
      #1;
      check_outs_zero("reset");
      i_rst_n = 1'b1;
      tick();
      check_value("ready_idle", 64'(o_host_ready), 64'd1);

      // Directed load of three entries.
      clear_ev();
      fill_rom(-1);
      rom[0] = {32'h0000_0400, 32'h0000_0007};
      rom[1] = {32'h0000_0500, 32'h0000_0006};
      rom[2] = {32'h0000_0300, 32'h0001_0000};
      boot_pulse(3, c);
      exp_boot(c, 3, dn);
      repeat (10) tick();
      check_all("boot3");
      check_busy(c + 1, dn);

      // Terminator at entry 1 of a 4-entry load.
      clear_ev();
      fill_rom(1);
      boot_pulse(4, c);
      exp_boot(c, 4, dn);
      repeat (12) tick();
      check_all("boot_term");
      check_busy(c + 1, dn);

      // Zero-length and full-ROM loads.
      clear_ev();
      boot_pulse(0, c);
      exp_boot(c, 0, dn);
      repeat (4) tick();
      check_all("boot_len0");
      check_busy(c + 1, dn);

      clear_ev();
      fill_rom(-1);
      boot_pulse(64, c);
      exp_boot(c, 64, dn);
      repeat (2 * 64 + 6) tick();
      check_all("boot_len64");
      check_busy(c + 1, dn);

      // Random loads, terminator inside, just past the end, or absent.
      for (int it = 0; it < 6; it++) begin
         len  = int'($urandom_range(20, 1));
         sel  = int'($urandom_range(2, 0));
         term = (sel == 0) ? int'($urandom_range(len - 1, 0)) : (sel == 1) ? len : -1;
         clear_ev();
         fill_rom(term);
         boot_pulse(len, c);
         exp_boot(c, len, dn);
         repeat (2 * len + 6) tick();
         check_all("boot_rand");
         check_busy(c + 1, dn);
      end

      // Host writes, back to back.
      clear_ev();
      host_write(32'h0000_0100, 32'h0000_0808, acc);
      host_write($urandom, $urandom, acc2);
      check_value("b2b_accept_cycle", 64'(acc2), 64'(acc + 1));
      repeat (3) tick();
      check_all("host_wr");

      // Host reads: response after 3 cycles, timeout, stray valid, last-cycle valid.
      clear_ev();
      host_read(32'h0000_0104, 3, 32'hDEAD_BEEF);
      host_read($urandom, -1, 32'h0);
      i_rule_rdata_valid = 1'b1;
      i_rule_rdata       = $urandom;
      tick();
      i_rule_rdata_valid = 1'b0;
      repeat (3) tick();
      host_read($urandom, RD_TIMEOUT - 1, $urandom);
      repeat (3) tick();
      check_all("host_rd");

      // Random host traffic.
      clear_ev();
      for (int it = 0; it < 20; it++) begin
         a = $urandom;
         d = $urandom;
         if ($urandom_range(1, 0) == 1) host_write(a, d, acc);
         else if ($urandom_range(3, 0) == 0) host_read(a, -1, d);
         else host_read(a, int'($urandom_range(RD_TIMEOUT - 1, 1)), d);
      end
      repeat (3) tick();
      check_all("host_rand");

      // Boot requested while a host read is outstanding.
      clear_ev();
      fill_rom(-1);
      a = $urandom;
      d = $urandom;
      host_req(1'b0, a, $urandom, acc);
      r = acc + 1;
      exp_rd.push_back(mk(r, {32'h0, a}));
      i_boot_start = 1'b1;
      i_boot_len   = 7'd4;
      tick();
      i_boot_len   = 7'd2;
      tick();
      i_boot_start = 1'b0;
      repeat (3) tick();
      i_rule_rdata_valid = 1'b1;
      i_rule_rdata       = d;
      tick();
      i_rule_rdata_valid = 1'b0;
      exp_rsp.push_back(mk(r + 6, {32'h0, d}));
      exp_boot(r + 6, 4, dn);
      a = $urandom;
      host_write(a, 32'h0000_5A5A, acc2);
      check_value("host_blocked_until_done", 64'(acc2), 64'(dn));
      repeat (3) tick();
      check_all("boot_during_rd");
      check_busy(r + 1, dn);

      // Reset in the middle of a load, then a fresh load from entry 0.
      clear_ev();
      fill_rom(-1);
      boot_pulse(8, c);
      repeat (5) tick();
      i_rst_n = 1'b0;
      #1;
      check_outs_zero("rst_midboot");
      tick();
      tick();
      i_rst_n = 1'b1;
      repeat (25) tick();
      check_value("rst_midboot_no_done", 64'(done_q.size()), 64'd0);
      clear_ev();
      boot_pulse(3, c);
      exp_boot(c, 3, dn);
      repeat (10) tick();
      check_all("boot_after_rst");

      // Reset while a host read is waiting.
      clear_ev();
      host_req(1'b0, $urandom, $urandom, acc);
      repeat (4) tick();
      i_rst_n = 1'b0;
      #1;
      check_outs_zero("rst_midread");
      tick();
      tick();
      i_rst_n = 1'b1;
      repeat (20) tick();
      check_value("rst_midread_no_rvalid", 64'(rsp_q.size()), 64'd0);

      check_value("wr_rd_exclusive", 64'(excl_viol), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/parser_rule_ctrl.md
Name: parser_rule_ctrl

Overview:
- Configuration controller sitting in front of the Parser_Top rule bus (i_rule_wren/i_rule_rden/i_rule_addr/i_rule_wdata/o_rule_rdata_valid/o_rule_rdata).
- Sequences a boot-time rule load from a config ROM: entries in the same address map as the rule bus (region in addr[10:8]: rules, type data/mask, type offset, key offset, head shift, meta shift).
- Arbitrates that load against single-word host reads and writes, and returns host read data with a timeout.
- Replaces forcing layer internals in benches with real rule-bus traffic.

Parameters:
- ROM_AW, 6, config ROM address width; max load length is 2^ROM_AW entries.
- RD_TIMEOUT, 16, cycles to wait for i_rule_rdata_valid after a host read is issued.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_boot_start  in  1  one-cycle pulse; start ROM load
- i_boot_len  in  ROM_AW+1  number of ROM entries to load
- o_boot_busy  out  1  high while a load is pending or in progress
- o_boot_done  out  1  one-cycle pulse when a load ends
- o_rom_rden  out  1  ROM read strobe
- o_rom_addr  out  ROM_AW  ROM entry index
- i_rom_data  in  64  {addr[63:32], wdata[31:0]}; valid one cycle after o_rom_rden
- i_host_valid  in  1  host request valid
- o_host_ready  out  1  host request accepted when valid&ready
- i_host_wr  in  1  1 = write, 0 = read
- i_host_addr  in  32  rule address
- i_host_wdata  in  32  write data
- o_host_rvalid  out  1  one-cycle read response pulse
- o_host_rdata  out  32  read data
- o_host_rerr  out  1  read timed out (qualified by o_host_rvalid)
- o_rule_wren  out  1  to Parser_Top i_rule_wren
- o_rule_rden  out  1  to Parser_Top i_rule_rden
- o_rule_addr  out  32  to Parser_Top i_rule_addr
- o_rule_wdata  out  32  to Parser_Top i_rule_wdata
- i_rule_rdata_valid  in  1  from Parser_Top o_rule_rdata_valid
- i_rule_rdata  in  32  from Parser_Top o_rule_rdata

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0; state IDLE; index, timeout counter and boot-pending flag cleared.
  - Reset mid-operation aborts with no o_boot_done and no o_host_rvalid.
- All outputs registered except o_host_ready = (state==IDLE) && !boot_pending && !i_boot_start.
- FSM states: IDLE, BOOT_RD, BOOT_WR, HOST_RD_WAIT.
- Boot request handling:
  - i_boot_start in any state sets boot_pending and latches i_boot_len.
  - Start pulses while boot_pending or a load is active are ignored; the first latched length is kept.
  - o_boot_busy = boot_pending || state in {BOOT_RD, BOOT_WR}.
- IDLE priority: boot_pending or i_boot_start first, then host.
  - Boot with len==0: o_boot_done pulses next cycle; stays IDLE.
  - Boot with len>0: index=0 → BOOT_RD.
- BOOT_RD:
  - o_rom_rden=1 and o_rom_addr=index for exactly one cycle → BOOT_WR.
- BOOT_WR (captures i_rom_data):
  - If addr==32'hFFFF_FFFF (terminator): no write; o_boot_done pulse; → IDLE.
  - Otherwise o_rule_wren=1 for one cycle with o_rule_addr/o_rule_wdata from the entry.
  - If index==len-1: o_boot_done pulses in the same cycle as the last write; → IDLE.
  - Else index+1 → BOOT_RD.
  - Throughput: one write per 2 cycles.
- Host write accepted at cycle T:
  - o_rule_wren=1 at T+1 with o_rule_addr=i_host_addr and o_rule_wdata=i_host_wdata.
  - Stays IDLE; the next host request can be accepted at T+1.
- Host read accepted at T:
  - o_rule_rden=1 for one cycle at T+1 with o_rule_addr; → HOST_RD_WAIT, counter=0.
- HOST_RD_WAIT:
  - i_rule_rdata_valid → next cycle o_host_rvalid=1, o_host_rdata=i_rule_rdata, o_host_rerr=0; → IDLE.
  - Else counter++; when counter reaches RD_TIMEOUT-1 without valid → o_host_rvalid=1, o_host_rdata=0, o_host_rerr=1; → IDLE.
  - If valid arrives on the timeout cycle, valid wins.
- i_rule_rdata_valid outside HOST_RD_WAIT is ignored.
- o_rule_wren and o_rule_rden are never high together.
- o_rule_addr/o_rule_wdata hold their last values when the strobes are low.

Test Plan:
- Boot len=3, ROM {0x0000_0400,7},{0x0000_0500,6},{0x0000_0300,0x0001_0000}, each entry formatted as {addr, wdata} → o_rule_wren at 3 cycles spaced 2 apart with those pairs; o_boot_done coincides with the 3rd write; o_boot_busy high from the cycle after start until done.
- Boot len=4 with entry 1 = {0xFFFF_FFFF,x} → exactly one write (entry 0); o_boot_done in the terminator cycle.
- Host write addr=0x0000_0100 data=0x0808 while idle → ready=1; o_rule_wren next cycle with those values; back-to-back second write accepted the following cycle.
- Host read, i_rule_rdata_valid with 0xDEAD_BEEF 3 cycles after rden → o_host_rvalid with rdata=0xDEAD_BEEF, rerr=0. Same read with no valid → rvalid with rerr=1, rdata=0 RD_TIMEOUT cycles after rden.
- i_boot_start during HOST_RD_WAIT → host read completes first, then boot runs with the latched len; o_host_ready stays 0 until o_boot_done.
- i_rst_n asserted mid-boot → all outputs 0 immediately; no o_boot_done; the next i_boot_start restarts from ROM index 0.
